// File: rtl/tt_sweep_if.sv
// Stimulus/response bundle between a truth-table sweep checker and its environment.
// Optional mismatch-log signals exist only when TT_SWEEP_MISMATCH_LOG_EN is defined.
interface tt_sweep_if;
    logic        start;
    logic        abort;
    logic [3:0]  dut_in;
    logic        dut_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] captured;
`ifdef TT_SWEEP_MISMATCH_LOG_EN
    logic [3:0]  first_fail_idx;
    logic [4:0]  fail_count;

    modport master (
        output start, abort, dut_out,
        input  dut_in, busy, done, pass, captured, first_fail_idx, fail_count
    );
    modport slave (
        input  start, abort, dut_out,
        output dut_in, busy, done, pass, captured, first_fail_idx, fail_count
    );
`else
    modport master (
        output start, abort, dut_out,
        input  dut_in, busy, done, pass, captured
    );
    modport slave (
        input  start, abort, dut_out,
        output dut_in, busy, done, pass, captured
    );
`endif
endinterface

// File: rtl/tt_sweep_checker.sv
// Sweeps all 16 vectors into a 4-input gate, assembles its truth table and compares it to
// TT_EXPECTED. Defining TT_SWEEP_MISMATCH_LOG_EN adds first_fail_idx / fail_count.
module tt_sweep_checker #(
    parameter logic [15:0] TT_EXPECTED   = 16'hE605,
    parameter int          SETTLE_CYCLES = 2
) (
    input logic      clk,
    input logic      rst_n,
    tt_sweep_if.slave sweep
);

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] cap_q, cap_d;
    logic        pass_q, pass_d;
    logic        done_q, done_d;

    logic load, quit, sample, last;

    // abort outranks both start and sampling
    assign load   = (state_q == IDLE) && sweep.start && !sweep.abort;
    assign quit   = (state_q == RUN) && sweep.abort;
    assign sample = (state_q == RUN) && !sweep.abort && (cnt_q == 4'd0);
    assign last   = sample && (idx_q == 4'hF);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load)
            state_d = RUN;
        else if (quit || last)
            state_d = IDLE;
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        cap_d  = cap_q;
        pass_d = pass_q;
        done_d = 1'b0;
        if (load) begin
            idx_d  = '0;
            cnt_d  = SETTLE;
            cap_d  = '0;
            pass_d = 1'b0;
        end else if (quit) begin
            idx_d  = '0;
            pass_d = 1'b0;
        end else if (sample) begin
            // bit (15-idx) is ~idx for a 4-bit index
            cap_d[~idx_q] = sweep.dut_out;
            if (last) begin
                done_d = 1'b1;
                pass_d = (cap_d == TT_EXPECTED);
            end else begin
                idx_d = idx_q + 4'd1;
                cnt_d = SETTLE;
            end
        end else if (state_q == RUN) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    assign sweep.busy     = (state_q == RUN);
    assign sweep.dut_in   = idx_q;
    assign sweep.captured = cap_q;
    assign sweep.pass     = pass_q;
    assign sweep.done     = done_q;

`ifdef TT_SWEEP_MISMATCH_LOG_EN
    logic [3:0] ffi_q, ffi_d;
    logic [4:0] fcnt_q, fcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ffi_q  <= '0;
            fcnt_q <= '0;
        end else begin
            ffi_q  <= ffi_d;
            fcnt_q <= fcnt_d;
        end
    end

    always_comb begin
        ffi_d  = ffi_q;
        fcnt_d = fcnt_q;
        if (load) begin
            ffi_d  = '0;
            fcnt_d = '0;
        end else if (sample && (sweep.dut_out != TT_EXPECTED[~idx_q])) begin
            if (fcnt_q == 5'd0)
                ffi_d = idx_q;
            fcnt_d = fcnt_q + 5'd1;
        end
    end

    assign sweep.first_fail_idx = ffi_q;
    assign sweep.fail_count     = fcnt_q;
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: a cycle-count model checked every cycle plus directed sweeps.
// Mismatch-log checks compile in when TT_SWEEP_MISMATCH_LOG_EN is defined.
module tb_tt_sweep_checker;

    localparam logic [15:0] GOLDEN = 16'hE605;
    localparam int SETTLE_OF [2] = '{2, 0};

    logic clk = 1'b0;
    logic rst_n;
    logic start_v [2];
    logic abort_v [2];
    int   gate_mode;   // 0 golden gate, 1 stuck at 0, 2 inverted gate

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tt_sweep_if if_s2 ();
    tt_sweep_if if_s0 ();

    tt_sweep_checker #(.TT_EXPECTED(GOLDEN), .SETTLE_CYCLES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .sweep(if_s2.slave));
    tt_sweep_checker #(.TT_EXPECTED(GOLDEN), .SETTLE_CYCLES(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .sweep(if_s0.slave));

    function automatic logic gate(input int mode, input logic [3:0] v);
        logic [15:0] tt;
        tt = GOLDEN;
        case (mode)
            1:       return 1'b0;
            2:       return ~tt[4'hF - v];
            default: return tt[4'hF - v];
        endcase
    endfunction

    assign if_s2.start   = start_v[0];
    assign if_s2.abort   = abort_v[0];
    assign if_s2.dut_out = gate(gate_mode, if_s2.dut_in);
    assign if_s0.start   = start_v[1];
    assign if_s0.abort   = abort_v[1];
    assign if_s0.dut_out = gate(gate_mode, if_s0.dut_in);

    logic        busy_a [2];
    logic        done_a [2];
    logic        pass_a [2];
    logic [15:0] cap_a  [2];
    logic [3:0]  din_a  [2];
    assign busy_a[0] = if_s2.busy;     assign busy_a[1] = if_s0.busy;
    assign done_a[0] = if_s2.done;     assign done_a[1] = if_s0.done;
    assign pass_a[0] = if_s2.pass;     assign pass_a[1] = if_s0.pass;
    assign cap_a[0]  = if_s2.captured; assign cap_a[1]  = if_s0.captured;
    assign din_a[0]  = if_s2.dut_in;   assign din_a[1]  = if_s0.dut_in;
`ifdef TT_SWEEP_MISMATCH_LOG_EN
    logic [3:0] ffi_a [2];
    logic [4:0] fc_a  [2];
    assign ffi_a[0] = if_s2.first_fail_idx; assign ffi_a[1] = if_s0.first_fail_idx;
    assign fc_a[0]  = if_s2.fail_count;     assign fc_a[1]  = if_s0.fail_count;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time since the start edge decides which vector is live and when it is sampled.
    typedef struct {
        logic        run;
        int          t;
        logic [15:0] cap;
        logic        pass;
        logic        done;
        logic [3:0]  din;
        logic [3:0]  ff;
        logic [4:0]  fc;
    } model_t;

    model_t mdl [2];

    function automatic model_t model_reset();
        model_t m;
        m.run = 1'b0; m.t = 0; m.cap = '0; m.pass = 1'b0; m.done = 1'b0;
        m.din = '0; m.ff = '0; m.fc = '0;
        return m;
    endfunction

    function automatic model_t step(model_t m, logic st, logic ab, int s, int mode);
        model_t      n;
        int          k;
        logic        b;
        logic [15:0] g;
        n = m;
        g = GOLDEN;
        n.done = 1'b0;
        if (m.run) begin
            if (ab) begin
                n.run = 1'b0; n.pass = 1'b0; n.din = '0;
            end else begin
                n.t = m.t + 1;
                if (n.t % (s + 1) == 0) begin
                    k = n.t / (s + 1) - 1;
                    b = gate(mode, 4'(k));
                    n.cap[15 - k] = b;
                    if (b != g[15 - k]) begin
                        if (m.fc == 0) n.ff = 4'(k);
                        n.fc = m.fc + 5'd1;
                    end
                    if (k == 15) begin
                        n.run = 1'b0; n.done = 1'b1; n.pass = (n.cap == GOLDEN);
                    end else begin
                        n.din = 4'(k + 1);
                    end
                end
            end
        end else if (st && !ab) begin
            n.run = 1'b1; n.t = 0; n.cap = '0; n.pass = 1'b0; n.din = '0;
            n.ff = '0; n.fc = '0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mdl[i] <= model_reset();
        end else begin
            for (int i = 0; i < 2; i++)
                mdl[i] <= step(mdl[i], start_v[i], abort_v[i], SETTLE_OF[i], gate_mode);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("busy[%0d]", i), 32'(busy_a[i]), 32'(mdl[i].run));
            check($sformatf("done[%0d]", i), 32'(done_a[i]), 32'(mdl[i].done));
            check($sformatf("pass[%0d]", i), 32'(pass_a[i]), 32'(mdl[i].pass));
            check($sformatf("captured[%0d]", i), 32'(cap_a[i]), 32'(mdl[i].cap));
            check($sformatf("dut_in[%0d]", i), 32'(din_a[i]), 32'(mdl[i].din));
`ifdef TT_SWEEP_MISMATCH_LOG_EN
            check($sformatf("first_fail_idx[%0d]", i), 32'(ffi_a[i]), 32'(mdl[i].ff));
            check($sformatf("fail_count[%0d]", i), 32'(fc_a[i]), 32'(mdl[i].fc));
`endif
        end
    end

    // Start edge is clock 0; ra/rb re-pulse start and ab_at pulses abort at those clocks.
    task automatic run_sweep(input int sel, input int ra, input int rb, input int ab_at,
                             input int max_cyc, output int n, output bit got_done);
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        n = 0;
        got_done = 1'b0;
        while (n < max_cyc && !got_done) begin
            start_v[sel] = ((n + 1) == ra) || ((n + 1) == rb);
            abort_v[sel] = ((n + 1) == ab_at);
            @(posedge clk);
            #1;
            n++;
            if (done_a[sel]) got_done = 1'b1;
        end
        start_v[sel] = 1'b0;
        abort_v[sel] = 1'b0;
    endtask

    int n;
    bit got;

    initial begin
        rst_n = 1'b1;
        gate_mode = 0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(if_s2.busy), 32'd0);
        check("reset_done", 32'(if_s2.done), 32'd0);
        check("reset_pass", 32'(if_s2.pass), 32'd0);
        check("reset_captured", 32'(if_s2.captured), 32'd0);
        check("reset_dut_in", 32'(if_s2.dut_in), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // golden gate, SETTLE=2
        run_sweep(0, 0, 0, 0, 200, n, got);
        check("t1_done_seen", 32'(got), 32'd1);
        check("t1_done_clock", 32'(n), 32'd48);
        check("t1_captured", 32'(if_s2.captured), 32'hE605);
        check("t1_pass", 32'(if_s2.pass), 32'd1);
        check("t1_busy_after", 32'(if_s2.busy), 32'd0);
`ifdef TT_SWEEP_MISMATCH_LOG_EN
        check("t1_fail_count", 32'(if_s2.fail_count), 32'd0);
        check("t1_first_fail", 32'(if_s2.first_fail_idx), 32'd0);
`endif

        // output stuck at 0
        gate_mode = 1;
        run_sweep(0, 0, 0, 0, 200, n, got);
        check("t2_done_clock", 32'(n), 32'd48);
        check("t2_captured", 32'(if_s2.captured), 32'h0000);
        check("t2_pass", 32'(if_s2.pass), 32'd0);
`ifdef TT_SWEEP_MISMATCH_LOG_EN
        check("t2_fail_count", 32'(if_s2.fail_count), 32'd7);
        check("t2_first_fail", 32'(if_s2.first_fail_idx), 32'd0);
`endif

        // inverted gate
        gate_mode = 2;
        run_sweep(0, 0, 0, 0, 200, n, got);
        check("t3_done_clock", 32'(n), 32'd48);
        check("t3_captured", 32'(if_s2.captured), 32'h19FA);
        check("t3_pass", 32'(if_s2.pass), 32'd0);
`ifdef TT_SWEEP_MISMATCH_LOG_EN
        check("t3_fail_count", 32'(if_s2.fail_count), 32'd16);
        check("t3_first_fail", 32'(if_s2.first_fail_idx), 32'd0);
`endif

        // start re-pulsed mid-sweep is ignored
        gate_mode = 0;
        run_sweep(0, 5, 20, 0, 200, n, got);
        check("t4_done_seen", 32'(got), 32'd1);
        check("t4_done_clock", 32'(n), 32'd48);
        check("t4_pass", 32'(if_s2.pass), 32'd1);

        // abort at clock 10: vectors 0..2 already sampled, sweep dropped
        run_sweep(0, 0, 0, 10, 60, n, got);
        check("t5_no_done", 32'(got), 32'd0);
        check("t5_busy", 32'(if_s2.busy), 32'd0);
        check("t5_dut_in", 32'(if_s2.dut_in), 32'd0);
        check("t5_pass", 32'(if_s2.pass), 32'd0);
        check("t5_captured_partial", 32'(if_s2.captured), 32'hE000);
        run_sweep(0, 0, 0, 0, 200, n, got);
        check("t5_rerun_clock", 32'(n), 32'd48);
        check("t5_rerun_pass", 32'(if_s2.pass), 32'd1);

        // abort and start together in IDLE: abort wins
        @(negedge clk);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        check("t5b_no_start", 32'(if_s2.busy), 32'd0);

        // reset mid-sweep at clock 30
        run_sweep(0, 0, 0, 0, 30, n, got);
        check("t6_no_done_before_reset", 32'(got), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(if_s2.busy), 32'd0);
        check("t6_done", 32'(if_s2.done), 32'd0);
        check("t6_pass", 32'(if_s2.pass), 32'd0);
        check("t6_captured", 32'(if_s2.captured), 32'd0);
        check("t6_dut_in", 32'(if_s2.dut_in), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // SETTLE=0 instance samples every clock
        run_sweep(1, 0, 0, 0, 100, n, got);
        check("t6_s0_done_seen", 32'(got), 32'd1);
        check("t6_s0_done_clock", 32'(n), 32'd16);
        check("t6_s0_captured", 32'(if_s0.captured), 32'hE605);
        check("t6_s0_pass", 32'(if_s0.pass), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
